// File: rtl/tvp_stream_gen.sv
// TVP7002-style video source: RGB888 + HSYNC/VSYNC/FID with registered outputs.
// Optional interlaced timing is compiled in when INTERLACE_EN is defined.
module tvp_stream_gen #(
  parameter int H_W = 12,
  parameter int V_W = 11
) (
  input  logic           PCLK_in,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [H_W-1:0] cfg_htotal,
  input  logic [7:0]     cfg_hsync_len,
  input  logic [H_W-1:0] cfg_hact_start,
  input  logic [H_W-1:0] cfg_hact_len,
  input  logic [V_W-1:0] cfg_vtotal,
  input  logic [3:0]     cfg_vsync_len,
  input  logic [V_W-1:0] cfg_vact_start,
  input  logic [V_W-1:0] cfg_vact_len,
  input  logic [1:0]     cfg_pattern,
  input  logic           cfg_interlace,
  output logic [7:0]     R_out,
  output logic [7:0]     G_out,
  output logic [7:0]     B_out,
  output logic           HSYNC_out,
  output logic           VSYNC_out,
  output logic           FID_out,
  output logic           frame_start,
  output logic           cfg_err
);

  logic [H_W-1:0] sh_htotal_reg, sh_hact_start_reg, sh_hact_len_reg;
  logic [7:0]     sh_hsync_len_reg;
  logic [V_W-1:0] sh_vtotal_reg, sh_vact_start_reg, sh_vact_len_reg;
  logic [3:0]     sh_vsync_len_reg;
  logic [1:0]     sh_pattern_reg;

  logic           running_reg, cfg_err_reg, field_reg;
  logic [H_W-1:0] h_reg;
  logic [V_W-1:0] v_reg;
  logic [H_W-1:0] bar_cnt_reg;
  logic [2:0]     bar_idx_reg;

  logic [23:0]    rgb_reg;
  logic           hsync_reg, vsync_reg, fid_reg, fs_reg;

  logic           il_mode, in_valid, load_en;
  logic           h_last, v_last, frame_wrap, h_in_act, v_in_act, vs_low;
  logic [H_W:0]   in_hact_end, hact_end, half_line;
  logic [V_W:0]   in_vact_end, vact_end;
  logic [V_W-1:0] v_end, vsync_ext;
  logic [H_W-1:0] bar_w;
  logic [7:0]     x_lo;
  logic [3:0]     y_lo;
  logic [2:0]     bar_bits;
  logic [23:0]    bar_rgb, rgb_next;

  // Validity is judged on the live inputs, since they are what a load captures.
  assign in_hact_end = {1'b0, cfg_hact_start} + {1'b0, cfg_hact_len};
  assign in_vact_end = {1'b0, cfg_vact_start} + {1'b0, cfg_vact_len};
  assign in_valid = (cfg_htotal >= H_W'(16))
                 && ({{(H_W-8){1'b0}}, cfg_hsync_len} < cfg_htotal)
                 && (in_hact_end <= {1'b0, cfg_htotal})
                 && (cfg_vtotal >= V_W'(4))
                 && ({{(V_W-4){1'b0}}, cfg_vsync_len} < cfg_vtotal)
                 && (in_vact_end <= {1'b0, cfg_vtotal});

  assign h_last     = (h_reg == sh_htotal_reg - H_W'(1));
  assign v_end      = field_reg ? sh_vtotal_reg : sh_vtotal_reg - V_W'(1);
  assign v_last     = (v_reg == v_end);
  assign frame_wrap = h_last && v_last && (field_reg || !il_mode);
  assign load_en    = !enable || !running_reg || frame_wrap;

`ifdef INTERLACE_EN
  logic sh_interlace_reg;
  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n)     sh_interlace_reg <= 1'b0;
    else if (load_en) sh_interlace_reg <= cfg_interlace;
  end
  assign il_mode = sh_interlace_reg;
`else
  logic unused_interlace;
  assign unused_interlace = cfg_interlace;
  assign il_mode = 1'b0;
`endif

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      sh_htotal_reg     <= '0;
      sh_hsync_len_reg  <= '0;
      sh_hact_start_reg <= '0;
      sh_hact_len_reg   <= '0;
      sh_vtotal_reg     <= '0;
      sh_vsync_len_reg  <= '0;
      sh_vact_start_reg <= '0;
      sh_vact_len_reg   <= '0;
      sh_pattern_reg    <= '0;
    end else if (load_en) begin
      sh_htotal_reg     <= cfg_htotal;
      sh_hsync_len_reg  <= cfg_hsync_len;
      sh_hact_start_reg <= cfg_hact_start;
      sh_hact_len_reg   <= cfg_hact_len;
      sh_vtotal_reg     <= cfg_vtotal;
      sh_vsync_len_reg  <= cfg_vsync_len;
      sh_vact_start_reg <= cfg_vact_start;
      sh_vact_len_reg   <= cfg_vact_len;
      sh_pattern_reg    <= cfg_pattern;
    end
  end

  // Every load restarts timing at h=0,v=0 of field 0; a bad load parks the generator.
  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      running_reg <= 1'b0;
      cfg_err_reg <= 1'b0;
      h_reg       <= '0;
      v_reg       <= '0;
      field_reg   <= 1'b0;
    end else if (load_en) begin
      running_reg <= enable && in_valid;
      cfg_err_reg <= !in_valid;
      h_reg       <= '0;
      v_reg       <= '0;
      field_reg   <= 1'b0;
    end else if (h_last) begin
      h_reg <= '0;
      if (v_last) begin
        v_reg     <= '0;
        field_reg <= ~field_reg;
      end else begin
        v_reg <= v_reg + V_W'(1);
      end
    end else begin
      h_reg <= h_reg + H_W'(1);
    end
  end

  assign hact_end = {1'b0, sh_hact_start_reg} + {1'b0, sh_hact_len_reg};
  assign vact_end = {1'b0, sh_vact_start_reg} + {1'b0, sh_vact_len_reg};
  assign h_in_act = (h_reg >= sh_hact_start_reg) && ({1'b0, h_reg} < hact_end);
  assign v_in_act = (v_reg >= sh_vact_start_reg) && ({1'b0, v_reg} < vact_end);

  // Bar position tracked incrementally so no divider is needed for hact_len/8.
  assign bar_w = {3'b000, sh_hact_len_reg[H_W-1:3]};
  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
    end else if (load_en || h_last || !h_in_act) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
    end else if (bar_cnt_reg == bar_w - H_W'(1)) begin
      bar_cnt_reg <= '0;
      if (bar_idx_reg != 3'd7) bar_idx_reg <= bar_idx_reg + 3'd1;
    end else begin
      bar_cnt_reg <= bar_cnt_reg + H_W'(1);
    end
  end

  assign bar_bits = {~bar_idx_reg[1], ~bar_idx_reg[2], ~bar_idx_reg[0]};
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bar_chan
      assign bar_rgb[gi*8 +: 8] = {8{bar_bits[gi]}};
    end
  endgenerate

  assign x_lo = h_reg[7:0] - sh_hact_start_reg[7:0];
  assign y_lo = v_reg[3:0] - sh_vact_start_reg[3:0];

  always_comb begin
    rgb_next = '0;
    if (h_in_act && v_in_act) begin
      case (sh_pattern_reg)
        2'd1:    rgb_next = bar_rgb;
        2'd2:    rgb_next = {3{x_lo}};
        2'd3:    rgb_next = (x_lo[3] ^ y_lo[3]) ? 24'hFFFFFF : 24'h000000;
        default: rgb_next = '0;
      endcase
    end
  end

  // Field 1 VSYNC is shifted by half a line.
  assign half_line = {2'b00, sh_htotal_reg[H_W-1:1]};
  assign vsync_ext = {{(V_W-4){1'b0}}, sh_vsync_len_reg};
  always_comb begin
    vs_low = (v_reg < vsync_ext);
    if (field_reg) begin
      vs_low = ((v_reg == '0) && ({1'b0, h_reg} >= half_line))
            || ((v_reg != '0) && (v_reg < vsync_ext))
            || ((v_reg == vsync_ext) && ({1'b0, h_reg} < half_line));
    end
  end

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      rgb_reg   <= '0;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      fid_reg   <= 1'b0;
      fs_reg    <= 1'b0;
    end else if (!running_reg) begin
      rgb_reg   <= '0;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      fid_reg   <= 1'b0;
      fs_reg    <= 1'b0;
    end else begin
      rgb_reg   <= rgb_next;
      hsync_reg <= !(h_reg < {{(H_W-8){1'b0}}, sh_hsync_len_reg});
      vsync_reg <= !vs_low;
      fid_reg   <= field_reg;
      fs_reg    <= (h_reg == '0) && (v_reg == '0) && !field_reg;
    end
  end

  assign R_out       = rgb_reg[23:16];
  assign G_out       = rgb_reg[15:8];
  assign B_out       = rgb_reg[7:0];
  assign HSYNC_out   = hsync_reg;
  assign VSYNC_out   = vsync_reg;
  assign FID_out     = fid_reg;
  assign frame_start = fs_reg;
  assign cfg_err     = cfg_err_reg;

endmodule
